// File: rtl/knn_sched_if.sv
// Signal bundle between knn_sched and its surroundings (CPU regs, training RAM, knn_core).
// slave = the scheduler itself, master = everything that drives it.
interface knn_sched_if #(
   parameter int DATA_W  = 32,
   parameter int COORD_W = 16,
   parameter int LABEL_W = 8,
   parameter int K       = 4,
   parameter int NPTS_W  = 8
) ();
   logic                           clr;
   logic                           start;
   logic [NPTS_W-1:0]              n_points;
   logic [COORD_W-1:0]             test_x;
   logic [COORD_W-1:0]             test_y;
   logic                           mem_en;
   logic [NPTS_W-1:0]              mem_addr;
   logic [LABEL_W+2*COORD_W-1:0]   mem_rdata;
   logic                           dist_en;
   logic [COORD_W-1:0]             dist_x1;
   logic [COORD_W-1:0]             dist_y1;
   logic [COORD_W-1:0]             dist_x2;
   logic [COORD_W-1:0]             dist_y2;
   logic [2*DATA_W-1:0]            dist_value;
   logic                           busy;
   logic                           done;
   logic [K-1:0]                   nn_valid;
   logic [K*LABEL_W-1:0]           nn_label;
   logic [2*DATA_W-1:0]            nn_dist0;

   modport slave (
      input  clr, start, n_points, test_x, test_y, mem_rdata, dist_value,
      output mem_en, mem_addr, dist_en, dist_x1, dist_y1, dist_x2, dist_y2,
             busy, done, nn_valid, nn_label, nn_dist0
   );
   modport master (
      output clr, start, n_points, test_x, test_y, mem_rdata, dist_value,
      input  mem_en, mem_addr, dist_en, dist_x1, dist_y1, dist_x2, dist_y2,
             busy, done, nn_valid, nn_label, nn_dist0
   );
endinterface

// File: rtl/knn_sched.sv
// KNN scan sequencer: walks the training RAM, drives knn_core and keeps a sorted
// list of the K nearest samples (entry 0 = nearest, ties keep the older entry first).
module knn_sched #(
   parameter int DATA_W   = 32,
   parameter int COORD_W  = 16,
   parameter int LABEL_W  = 8,
   parameter int K        = 4,
   parameter int NPTS_W   = 8,
   parameter int DIST_LAT = 1
) (
   input  logic      clk,
   input  logic      rst,
   knn_sched_if.slave bus
);
   localparam int DW    = 2*DATA_W;
   localparam int CNT_W = (DIST_LAT > 1) ? $clog2(DIST_LAT) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, CALC, INSERT, DONE} state_t;

   state_t                         state_q, state_d;
   logic [NPTS_W-1:0]              idx_q, idx_d, npts_q, npts_d, idx_inc;
   logic [COORD_W-1:0]             tx_q, tx_d, ty_q, ty_d, sx_q, sx_d, sy_q, sy_d;
   logic [LABEL_W-1:0]             slab_q, slab_d;
   logic [DW-1:0]                  nd_q, nd_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [K-1:0][DW-1:0]           ldist_q, ldist_d, ins_dist;
   logic [K-1:0][LABEL_W-1:0]      llab_q, llab_d, ins_lab;
   logic [K-1:0]                   lvld_q, lvld_d, ins_vld;
   logic                           mem_en_q, mem_en_d, dist_en_q, dist_en_d;
   logic                           busy_q, busy_d, done_q, done_d;
   logic [NPTS_W-1:0]              mem_addr_q, mem_addr_d;
   logic                           found;
   int                             pos;

   // Insertion point: first invalid slot or first strictly larger distance.
   always_comb begin
      found    = 1'b0;
      pos      = 0;
      ins_dist = ldist_q;
      ins_lab  = llab_q;
      ins_vld  = lvld_q;
      for (int i = 0; i < K; i++) begin
         if (!found && (!lvld_q[i] || (ldist_q[i] > nd_q))) begin
            found = 1'b1;
            pos   = i;
         end
      end
      for (int i = 1; i < K; i++) begin
         if (found && (i > pos)) begin
            ins_dist[i] = ldist_q[i-1];
            ins_lab[i]  = llab_q[i-1];
            ins_vld[i]  = lvld_q[i-1];
         end
      end
      for (int i = 0; i < K; i++) begin
         if (found && (i == pos)) begin
            ins_dist[i] = nd_q;
            ins_lab[i]  = slab_q;
            ins_vld[i]  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      npts_d  = npts_q;
      tx_d    = tx_q;
      ty_d    = ty_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      slab_d  = slab_q;
      nd_d    = nd_q;
      cnt_d   = cnt_q;
      ldist_d = ldist_q;
      llab_d  = llab_q;
      lvld_d  = lvld_q;
      idx_inc = idx_q + NPTS_W'(1);
      case (state_q)
         IDLE: if (bus.start) begin
            tx_d    = bus.test_x;
            ty_d    = bus.test_y;
            npts_d  = bus.n_points;
            idx_d   = '0;
            ldist_d = '0;
            llab_d  = '0;
            lvld_d  = '0;
            state_d = (bus.n_points == '0) ? DONE : FETCH;
         end
         FETCH: state_d = WAIT;
         WAIT: begin
            slab_d  = bus.mem_rdata[LABEL_W+2*COORD_W-1 -: LABEL_W];
            sx_d    = bus.mem_rdata[2*COORD_W-1 -: COORD_W];
            sy_d    = bus.mem_rdata[COORD_W-1:0];
            cnt_d   = '0;
            state_d = CALC;
         end
         CALC: if (cnt_q == CNT_W'(DIST_LAT-1)) begin
            nd_d    = bus.dist_value;
            state_d = INSERT;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         INSERT: begin
            ldist_d = ins_dist;
            llab_d  = ins_lab;
            lvld_d  = ins_vld;
            idx_d   = idx_inc;
            state_d = (idx_inc == npts_q) ? DONE : FETCH;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Soft clear overrides everything, including a same-cycle start.
      if (bus.clr) begin
         state_d = IDLE;
         idx_d   = '0;
         ldist_d = '0;
         llab_d  = '0;
         lvld_d  = '0;
      end
      mem_en_d   = (state_d == FETCH);
      mem_addr_d = (state_d == FETCH) ? idx_d : '0;
      dist_en_d  = (state_d == CALC);
      busy_d     = (state_d == FETCH) || (state_d == WAIT) ||
                   (state_d == CALC)  || (state_d == INSERT);
      done_d     = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         npts_q     <= '0;
         tx_q       <= '0;
         ty_q       <= '0;
         sx_q       <= '0;
         sy_q       <= '0;
         slab_q     <= '0;
         nd_q       <= '0;
         cnt_q      <= '0;
         ldist_q    <= '0;
         llab_q     <= '0;
         lvld_q     <= '0;
         mem_en_q   <= 1'b0;
         mem_addr_q <= '0;
         dist_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         npts_q     <= npts_d;
         tx_q       <= tx_d;
         ty_q       <= ty_d;
         sx_q       <= sx_d;
         sy_q       <= sy_d;
         slab_q     <= slab_d;
         nd_q       <= nd_d;
         cnt_q      <= cnt_d;
         ldist_q    <= ldist_d;
         llab_q     <= llab_d;
         lvld_q     <= lvld_d;
         mem_en_q   <= mem_en_d;
         mem_addr_q <= mem_addr_d;
         dist_en_q  <= dist_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.mem_en   = mem_en_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.dist_en  = dist_en_q;
   assign bus.dist_x1  = tx_q;
   assign bus.dist_y1  = ty_q;
   assign bus.dist_x2  = sx_q;
   assign bus.dist_y2  = sy_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.nn_valid = lvld_q;
   assign bus.nn_label = llab_q;
   assign bus.nn_dist0 = ldist_q[0];
endmodule

// File: tb/tb_knn_sched.sv
// Bench for knn_sched: RAM + distance model, directed scans, scoreboard on done.
module tb_knn_sched;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   knn_sched_if bus ();
   knn_sched dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0]  mlab [16];
   logic [63:0] dtab [16];

   // RAM returns {label, x=addr, y=0}; the distance model keys its table on x2.
   always @(posedge clk) if (bus.mem_en) bus.mem_rdata <= {mlab[bus.mem_addr[3:0]], 8'h00, bus.mem_addr, 16'h0000};
   assign bus.dist_value = bus.dist_en ? dtab[bus.dist_x2[3:0]] : 64'd0;

   typedef struct { logic [3:0] vld; logic [31:0] lab; logic [63:0] d0; } exp_t;
   exp_t sb[$];
   exp_t e;
   int n_cmp = 0, n_bad = 0;
   int addr_log[$], addr_cyc[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no pulse");
         end else begin
            e = sb.pop_front();
            chk("nn_valid", 64'(bus.nn_valid), 64'(e.vld));
            chk("nn_label", 64'(bus.nn_label), 64'(e.lab));
            chk("nn_dist0", bus.nn_dist0, e.d0);
         end
      end
   end

   task automatic scan(input int n, input int inj_cyc, output int dcyc, output int nmem);
      @(negedge clk);
      bus.n_points = 8'(n); bus.test_x = 16'h1234; bus.test_y = 16'h0042; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      addr_log.delete(); addr_cyc.delete();
      nmem = 0; dcyc = -1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (bus.mem_en) begin nmem++; addr_log.push_back(int'(bus.mem_addr)); addr_cyc.push_back(c); end
         if (bus.done) begin dcyc = c; break; end
         if (c == inj_cyc) begin bus.start = 1'b1; bus.n_points = 8'd1; end
         else bus.start = 1'b0;
      end
      bus.start = 1'b0;
   endtask

   int dcyc, nmem, seen, ncalc;
   logic [7:0]  labs6 [6] = '{1, 2, 3, 4, 5, 6};
   logic [63:0] dsts6 [6] = '{9, 3, 7, 3, 1, 8};

   initial begin
      rst = 1'b0;
      bus.clr = 1'b0; bus.start = 1'b0; bus.n_points = '0; bus.test_x = '0; bus.test_y = '0;
      for (int i = 0; i < 16; i++) begin mlab[i] = 8'hEE; dtab[i] = 64'hFFFF; end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 0);
      chk("rst_done", 64'(bus.done), 0);
      chk("rst_mem_en", 64'(bus.mem_en), 0);
      chk("rst_dist_en", 64'(bus.dist_en), 0);
      chk("rst_nn_valid", 64'(bus.nn_valid), 0);
      @(negedge clk) rst = 1'b1;

      // N=0: immediate done, nothing fetched
      sb.push_back('{4'b0000, 32'h0, 64'd0});
      scan(0, -1, dcyc, nmem);
      chk("n0_done_cycle", 64'(dcyc), 1);
      chk("n0_mem_en_count", 64'(nmem), 0);

      // N=2: 50(1), 20(2)
      mlab[0] = 8'd1; dtab[0] = 64'd50;
      mlab[1] = 8'd2; dtab[1] = 64'd20;
      sb.push_back('{4'b0011, 32'h0000_0102, 64'd20});
      scan(2, -1, dcyc, nmem);
      chk("n2_done_cycle", 64'(dcyc), 9);

      // N=6: ties stay stable, larger entries dropped
      for (int i = 0; i < 6; i++) begin mlab[i] = labs6[i]; dtab[i] = dsts6[i]; end
      sb.push_back('{4'b1111, 32'h0304_0205, 64'd1});
      scan(6, -1, dcyc, nmem);
      chk("n6_done_cycle", 64'(dcyc), 25);

      // N=3 timing, all ties, with a start pulse injected mid-scan
      for (int i = 0; i < 3; i++) begin mlab[i] = 8'(7 + i); dtab[i] = 64'd5; end
      sb.push_back('{4'b0111, 32'h0009_0807, 64'd5});
      scan(3, 6, dcyc, nmem);
      chk("n3_done_cycle", 64'(dcyc), 13);
      chk("n3_mem_en_count", 64'(nmem), 3);
      for (int i = 0; i < 3 && i < addr_log.size(); i++) begin
         chk("n3_mem_addr", 64'(addr_log[i]), 64'(i));
         chk("n3_mem_cycle", 64'(addr_cyc[i]), 64'(1 + 4*i));
      end

      // clr + start together: clear wins, nothing starts
      @(negedge clk);
      bus.clr = 1'b1; bus.start = 1'b1; bus.n_points = 8'd2;
      @(posedge clk); #1 bus.clr = 1'b0; bus.start = 1'b0;
      chk("clr_busy", 64'(bus.busy), 0);
      chk("clr_nn_valid", 64'(bus.nn_valid), 0);
      seen = 0;
      repeat (20) begin @(negedge clk); if (bus.busy || bus.done || bus.mem_en) seen++; end
      chk("clr_no_activity", 64'(seen), 0);

      // async reset in the second CALC of an N=6 scan
      for (int i = 0; i < 6; i++) begin mlab[i] = labs6[i]; dtab[i] = dsts6[i]; end
      @(negedge clk);
      bus.n_points = 8'd6; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      ncalc = 0;
      for (int c = 0; c < 40 && ncalc < 2; c++) begin
         @(negedge clk);
         if (bus.dist_en) ncalc++;
      end
      chk("rstmid_reached_calc", 64'(ncalc), 2);
      chk("rstmid_pre_valid", 64'(bus.nn_valid), 64'b0001);
      #1 rst = 1'b0;
      #1;
      chk("rstmid_busy", 64'(bus.busy), 0);
      chk("rstmid_nn_valid", 64'(bus.nn_valid), 0);
      chk("rstmid_mem_en", 64'(bus.mem_en), 0);
      chk("rstmid_dist_en", 64'(bus.dist_en), 0);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
